// File: rtl/storage_delay_line.sv
// Programmable delay line: DEPTH clock-enabled register stages with per-stage valid and a runtime tap mux.
// Optional per-stage even parity with error injection is enabled by defining STORAGE_DELAY_LINE_PARITY_EN.

module storage_delay_line_stage #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] word_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word_q <= '0;
        end else if (en) begin
            word_q <= d_i;
        end
    end

    assign q_o = word_q;

endmodule

module storage_delay_line #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int SELW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [SELW-1:0]  tap_sel,
`ifdef STORAGE_DELAY_LINE_PARITY_EN
    input  logic             inj_err,
    output logic             q_perr,
`endif
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             tap_err,
    output logic [WIDTH-1:0] q_last,
    output logic             q_last_valid,
    output logic [SELW-1:0]  count
);

    // Stage word layout: {parity (optional), valid, data}.
`ifdef STORAGE_DELAY_LINE_PARITY_EN
    localparam int EW = WIDTH + 2;
`else
    localparam int EW = WIDTH + 1;
`endif

    logic [EW-1:0]   chain [0:DEPTH];
    logic [EW-1:0]   tap_word;
    logic [SELW-1:0] count_q;
    logic [SELW-1:0] count_d;

`ifdef STORAGE_DELAY_LINE_PARITY_EN
    assign chain[0] = {(^d) ^ inj_err, d_valid, d};
`else
    assign chain[0] = {d_valid, d};
`endif

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        storage_delay_line_stage #(.W(EW)) u_stage (
            .clk (clk),
            .rst (rst),
            .clr (flush),
            .en  (en),
            .d_i (chain[k-1]),
            .q_o (chain[k])
        );
    end

    // Occupancy tracks beats entering minus the valid beat falling off the end.
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + SELW'(d_valid) - SELW'(chain[DEPTH][WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        q        = '0;
        q_valid  = 1'b0;
        tap_err  = 1'b0;
        tap_word = '0;
`ifdef STORAGE_DELAY_LINE_PARITY_EN
        q_perr   = 1'b0;
`endif
        if (tap_sel == '0) begin
            q       = d;
            q_valid = d_valid;
        end else if (tap_sel <= SELW'(DEPTH)) begin
            tap_word = chain[tap_sel];
            q        = tap_word[WIDTH-1:0];
            q_valid  = tap_word[WIDTH];
`ifdef STORAGE_DELAY_LINE_PARITY_EN
            q_perr   = tap_word[WIDTH] & ((^tap_word[WIDTH-1:0]) ^ tap_word[WIDTH+1]);
`endif
        end else begin
            tap_err = 1'b1;
        end
    end

    assign q_last       = chain[DEPTH][WIDTH-1:0];
    assign q_last_valid = chain[DEPTH][WIDTH];
    assign count        = count_q;

endmodule

// File: tb/tb_storage_delay_line.sv
// Directed bench for storage_delay_line: queue-style reference model checked every cycle plus literal spot checks.
module tb_storage_delay_line;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SELW  = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             d_valid = 1'b0;
    logic [SELW-1:0]  tap_sel = '0;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             tap_err;
    logic [WIDTH-1:0] q_last;
    logic             q_last_valid;
    logic [SELW-1:0]  count;
`ifdef STORAGE_DELAY_LINE_PARITY_EN
    logic             inj_err = 1'b0;
    logic             q_perr;
`endif

    int   n_pass = 0;
    int   n_total = 0;
    logic chk_on = 1'b0;

    storage_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .flush        (flush),
        .d            (d),
        .d_valid      (d_valid),
        .tap_sel      (tap_sel),
`ifdef STORAGE_DELAY_LINE_PARITY_EN
        .inj_err      (inj_err),
        .q_perr       (q_perr),
`endif
        .q            (q),
        .q_valid      (q_valid),
        .tap_err      (tap_err),
        .q_last       (q_last),
        .q_last_valid (q_last_valid),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain array of beats, index 1 = newest.
    logic [WIDTH-1:0] m_data [1:DEPTH];
    logic             m_vld  [1:DEPTH];
`ifdef STORAGE_DELAY_LINE_PARITY_EN
    logic             m_bad  [1:DEPTH];
`endif

    always @(posedge clk) begin
        if (rst || flush) begin
            for (int k = 1; k <= DEPTH; k++) begin
                m_data[k] <= '0;
                m_vld[k]  <= 1'b0;
`ifdef STORAGE_DELAY_LINE_PARITY_EN
                m_bad[k]  <= 1'b0;
`endif
            end
        end else if (en) begin
            for (int k = 2; k <= DEPTH; k++) begin
                m_data[k] <= m_data[k-1];
                m_vld[k]  <= m_vld[k-1];
`ifdef STORAGE_DELAY_LINE_PARITY_EN
                m_bad[k]  <= m_bad[k-1];
`endif
            end
            m_data[1] <= d;
            m_vld[1]  <= d_valid;
`ifdef STORAGE_DELAY_LINE_PARITY_EN
            m_bad[1]  <= inj_err;
`endif
        end
    end

    always @(negedge clk) begin
        logic [WIDTH-1:0] eq;
        logic             ev;
        logic             ee;
        int               cnt;
        int               t;
        if (chk_on) begin
            t  = int'(tap_sel);
            eq = '0;
            ev = 1'b0;
            ee = 1'b0;
            if (t == 0) begin
                eq = d;
                ev = d_valid;
            end else if (t <= DEPTH) begin
                eq = m_data[t];
                ev = m_vld[t];
            end else begin
                ee = 1'b1;
            end
            cnt = 0;
            for (int k = 1; k <= DEPTH; k++) cnt += int'(m_vld[k]);
            chk("q", q, eq);
            chk("q_valid", q_valid, ev);
            chk("tap_err", tap_err, ee);
            chk("q_last", q_last, m_data[DEPTH]);
            chk("q_last_valid", q_last_valid, m_vld[DEPTH]);
            chk("count", count, cnt);
`ifdef STORAGE_DELAY_LINE_PARITY_EN
            chk("q_perr", q_perr, (t >= 1 && t <= DEPTH) ? (m_vld[t] & m_bad[t]) : 1'b0);
`endif
        end
    end

    task automatic drive(input logic r, input logic f, input logic e,
                         input logic [WIDTH-1:0] dd, input logic dv);
        rst     = r;
        flush   = f;
        en      = e;
        d       = dd;
        d_valid = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tap_sel = 3'd4;
        drive(1, 0, 1, 8'h00, 0);
        chk_on = 1'b1;
        chk("rst_q", q, 0);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_count", count, 0);
        drive(1, 0, 1, 8'h00, 0);
        chk("rst2_count", count, 0);

        // Fill
        drive(0, 0, 1, 8'h11, 1);
        chk("fill1_count", count, 1);
        drive(0, 0, 1, 8'h22, 1);
        chk("fill2_count", count, 2);
        drive(0, 0, 1, 8'h33, 1);
        chk("fill3_count", count, 3);
        drive(0, 0, 1, 8'h44, 1);
        chk("fill4_q", q, 8'h11);
        chk("fill4_q_valid", q_valid, 1);
        chk("fill4_count", count, 4);

        // Stall while d carries junk
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 8'hFF, 1);
            chk("stall_q_last", q_last, 8'h11);
            chk("stall_count", count, 4);
        end
        drive(0, 0, 1, 8'h55, 1);
        chk("resume_q_last", q_last, 8'h22);
        chk("resume_q", q, 8'h22);
        chk("resume_count", count, 4);

        // Flush wins over enable
        drive(0, 1, 1, 8'hAA, 1);
        chk("flush_count", count, 0);
        for (int t = 1; t <= DEPTH; t++) begin
            tap_sel = SELW'(t);
            #1;
            chk("flush_q_valid", q_valid, 0);
            chk("flush_q", q, 0);
        end

        // Bubbles and tap sweep
        tap_sel = 3'd1;
        drive(0, 0, 1, 8'h01, 1);
        drive(0, 0, 1, 8'h02, 0);
        drive(0, 0, 1, 8'h03, 1);
        en = 1'b0; d = 8'h77; d_valid = 1'b1;
        #1;
        chk("bub_t1_q", q, 8'h03);
        chk("bub_t1_v", q_valid, 1);
        tap_sel = 3'd2; #1;
        chk("bub_t2_q", q, 8'h02);
        chk("bub_t2_v", q_valid, 0);
        tap_sel = 3'd3; #1;
        chk("bub_t3_q", q, 8'h01);
        chk("bub_t3_v", q_valid, 1);
        chk("bub_count", count, 2);
        tap_sel = 3'd0; #1;
        chk("bypass_q", q, 8'h77);
        chk("bypass_v", q_valid, 1);
        tap_sel = 3'd5; #1;
        chk("tap5_q", q, 0);
        chk("tap5_v", q_valid, 0);
        chk("tap5_err", tap_err, 1);

        // Mid-stream reset
        tap_sel = 3'd4;
        drive(0, 1, 0, 8'h00, 0);
        drive(0, 0, 1, 8'h21, 1);
        drive(0, 0, 1, 8'h22, 1);
        drive(0, 0, 1, 8'h23, 1);
        chk("mid_pre_count", count, 3);
        drive(1, 0, 1, 8'h99, 1);
        chk("mid_count", count, 0);
        chk("mid_q_last_valid", q_last_valid, 0);
        tap_sel = 3'd1; #1;
        chk("mid_t1_v", q_valid, 0);
        chk("mid_t1_q", q, 0);

`ifdef STORAGE_DELAY_LINE_PARITY_EN
        tap_sel = 3'd2;
        drive(0, 1, 0, 8'h00, 0);
        inj_err = 1'b1;
        drive(0, 0, 1, 8'h5A, 1);
        inj_err = 1'b0;
        drive(0, 0, 1, 8'h5A, 1);
        chk("par_bad", q_perr, 1);
        drive(0, 0, 1, 8'h00, 1);
        chk("par_good", q_perr, 0);
        drive(0, 1, 0, 8'h00, 0);
        chk("par_flush", q_perr, 0);
`endif

        // Mixed traffic against the model
        for (int i = 0; i < 80; i++) begin
            tap_sel = SELW'($urandom_range(0, (1 << SELW) - 1));
`ifdef STORAGE_DELAY_LINE_PARITY_EN
            inj_err = 1'($urandom_range(0, 3) == 0);
`endif
            drive(i == 40, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                  WIDTH'($urandom), 1'($urandom));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
